pcg_rr_server: RTL
==================

# pcg_rr_server

Shared random-number server: one PCG XSH-RR 32-bit generator core time-shared between N requesters by a round-robin arbiter. It owns the seeding sequence (pcg32-style init: zero, step, add seed, step), then serves at most one 32-bit value per cycle, advancing the generator exactly once per grant. It sits between the PCG datapath and the consumer blocks (test-pattern engines, dither, scramblers) so no stream value is ever delivered twice or skipped.

## Interface
- N, 4: number of requesters, 2..16.
- A, 64'd6364136223846793005: LCG multiplier.
- C, 64'd1442695040888963407: LCG increment, must be odd.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- Seed  in  64  seed value, sampled in state ADD only.
- reseed  in  1  single-cycle pulse; restarts the seeding sequence.
- req  in  N  per-requester request level.
- gnt  out  N  one-hot grant, valid for one cycle, registered.
- rnd  out  32  random value for the granted requester, valid while |gnt.
- busy  out  1  high while seeding (no grants possible).

## Operation
- Registers: state[63:0], fsm {ZERO, ADD, WARM, RUN}, last[$clog2(N)-1:0] (last granted index), gnt, rnd.
- Step: state <= state*A + C, mod 2^64 by truncation.
- XSH-RR of state s: xs = (((s>>18)^s)>>27)[31:0]; rot = s[63:59]; out = (xs>>rot) | (xs<<((32-rot)&31)). Output always derives from the pre-step state.
- FSM:
  - ZERO: state <= 0*A+C = C; -> ADD.
  - ADD: state <= state + Seed; -> WARM.
  - WARM: step; -> RUN.
  - RUN: if any req bit set, grant winner, rnd <= XSH-RR(state), step; else state holds, gnt <= 0.
- Post-init state = ((C+Seed)*A + C) mod 2^64.
- Arbitration: search starts at (last+1) mod N, first set req bit wins; last <= winner. Non-requesting cycles leave last unchanged.
- Requester protocol: keep req high until own gnt bit seen; drop req in the cycle gnt is seen if no further value wanted (a req still high in that cycle is a new request).
- reseed: in any state, forces fsm to ZERO next cycle; a grant is not issued in the cycle reseed is high; last is not reset.
- No grants during ZERO/ADD/WARM; req held through seeding is served once RUN is reached.

## Timing
- Reset (async assert): state=0, fsm=ZERO, last=N-1 (requester 0 first), gnt=0, rnd=0, busy=1.
- After rst deasserts: ZERO, ADD, WARM occupy 3 clocks; busy=0 and first grant possible on the 4th edge.
- busy = (fsm != RUN), combinational from fsm.
- Request latency: req sampled at edge t (RUN) -> gnt/rnd valid after edge t, for exactly one cycle.
- Throughput: one grant per clock when requests pending; with all N requesting continuously each gets one grant every N cycles.
- gnt and rnd change only together; rnd holds its last value when gnt=0.
- rst asserted mid-operation: immediate clear as above, in-flight grant discarded.
- reseed in RUN with pending req: that cycle gnt=0, then 3 seeding clocks, then service resumes from the new stream.

## Test plan
- Params A=1, C=1, Seed=64'hF800_0000_0000_0000, req=4'b0001 held from reset -> busy high 3 cycles, first gnt=4'b0001 with rnd=32'h000F_8000 (state ...0002, rot=31), state then ...0003.
- Default params, Seed=0, one requester pulsing -> rnd sequence equals software pcg32 model seeded with state=C*A+C (mod 2^64), 1000 values, no repeats/skips.
- req=4'b1111 held continuously in RUN -> gnt sequence 0001,0010,0100,1000,0001,... ; each rnd equals next model value in order.
- req=4'b1010 held, then req[1] dropped after its grant -> grants 0010,1000,1000,1000; last tracking correct.
- reseed pulsed with req=4'b0001 high -> that cycle gnt=0, busy=1 for 3 cycles, next rnd equals first value of freshly seeded model stream.
- rst asserted asynchronously between edges while gnt active -> gnt=0, rnd=0, busy=1 immediately; post-release behaviour identical to power-on.

Source files
------------

// File: rtl/pcg_rr_server.sv
// pcg_rr_server: one PCG XSH-RR 32-bit generator shared by N requesters
// through a round-robin arbiter. The block runs the pcg32-style seeding
// sequence itself, then serves at most one value per clock. The generator
// advances exactly once per grant, so no stream value is delivered twice
// or skipped.
module pcg_rr_server #(
  parameter int          N = 4,
  parameter logic [63:0] A = 64'd6364136223846793005,
  parameter logic [63:0] C = 64'd1442695040888963407
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   Seed,
  input  logic          reseed,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [31:0]   rnd,
  output logic          busy
);

  localparam int LW = $clog2(N);

  localparam logic [1:0] ST_ZERO = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_WARM = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  logic [63:0]   state_q, state_d;
  logic [1:0]    fsm_q,   fsm_d;
  logic [LW-1:0] last_q,  last_d;
  logic [N-1:0]  gnt_q,   gnt_d;
  logic [31:0]   rnd_q,   rnd_d;

  logic          found;
  logic [LW-1:0] winner;
  logic [LW-1:0] cand;

  // One LCG step; the product wraps modulo 2^64 by truncation.
  function automatic logic [63:0] lcg_step(input logic [63:0] s);
    return s * A + C;
  endfunction

  // XSH-RR output permutation of a (pre-step) state.
  function automatic logic [31:0] xsh_rr(input logic [63:0] s);
    logic [31:0] xs;
    logic [4:0]  rot;
    xs  = 32'(((s >> 18) ^ s) >> 27);
    rot = s[63:59];
    // (32 - rot) & 31 is simply -rot modulo 32.
    return (xs >> rot) | (xs << (5'd0 - rot));
  endfunction

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch
    // can be inferred whichever path the logic takes.
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= N; i++) begin
      cand = LW'((int'(last_q) + i) % N);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Seeding sequence, grant issue and generator advance.
  always_comb begin
    state_d = state_q;
    fsm_d   = fsm_q;
    last_d  = last_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    case (fsm_q)
      ST_ZERO: begin
        state_d = C;                  // 0*A + C
        fsm_d   = ST_ADD;
      end
      ST_ADD: begin
        state_d = state_q + Seed;
        fsm_d   = ST_WARM;
      end
      ST_WARM: begin
        state_d = lcg_step(state_q);
        fsm_d   = ST_RUN;
      end
      default: begin                  // ST_RUN
        if (found) begin
          gnt_d   = N'(1) << winner;
          rnd_d   = xsh_rr(state_q);
          state_d = lcg_step(state_q);
          last_d  = winner;
        end
      end
    endcase
    // A reseed pre-empts everything, including a grant that would
    // otherwise go out this cycle; the arbiter pointer is kept.
    if (reseed) begin
      state_d = state_q;
      fsm_d   = ST_ZERO;
      last_d  = last_q;
      gnt_d   = '0;
      rnd_d   = rnd_q;
    end
  end

  // State registers; reset clears everything and points the arbiter so
  // that requester 0 is considered first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      fsm_q   <= ST_ZERO;
      last_q  <= LW'(N - 1);
      gnt_q   <= '0;
      rnd_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      fsm_q   <= fsm_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
    end
  end

  assign gnt  = gnt_q;
  assign rnd  = rnd_q;
  assign busy = (fsm_q != ST_RUN);

endmodule
